// File: rtl/fetch_pkg.sv
// Shared types and sizes for the IF-stage fetch path.
// Contents:
//   fetch_entry_t : {pc, instr} pair buffered toward IF/ID
//   FETCH_DEPTH   : return-queue depth (2)
//   INSTR_NOP     : canonical nop (addi x0,x0,0)
package fetch_pkg;

  localparam int unsigned FETCH_PC_W  = 9;
  localparam int unsigned FETCH_INS_W = 32;
  localparam int unsigned FETCH_DEPTH = 2;
  localparam int unsigned FETCH_CNT_W = 2;

  localparam logic [FETCH_INS_W-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_PC_W-1:0]  pc;
    logic [FETCH_INS_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO of fetch_entry_t with synchronous clear.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   push/wdata : enqueue (ignored when full unless a pop happens the same cycle)
//   pop        : dequeue head (ignored when empty)
//   clear      : drop all entries; overrides push and pop
//   rdata      : head entry (contents undefined-but-stable when empty)
//   count      : number of entries held, 0..2
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           rdata,
  output logic [FETCH_CNT_W-1:0] count
);

  localparam logic [FETCH_CNT_W-1:0] FULL_CNT = FETCH_CNT_W'(FETCH_DEPTH);

  fetch_entry_t            mem_q [FETCH_DEPTH];
  fetch_entry_t            mem_d [FETCH_DEPTH];
  // Single-bit pointers: depth is fixed at two entries.
  logic                    rd_ptr_q, rd_ptr_d;
  logic                    wr_ptr_q, wr_ptr_d;
  logic [FETCH_CNT_W-1:0]  count_q, count_d;
  logic                    do_push, do_pop;

  // Pointer/count update; pop is resolved first so push+pop at full is legal.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    if (clear) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + FETCH_CNT_W'(do_push) - FETCH_CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    rdata = mem_q[rd_ptr_q];
    count = count_q;
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// IF-stage PC generator with branch redirect.
// Holds the PC, issues sequential fetches to a 1-cycle synchronous imem and queues
// returned {pc,instr} pairs (2 entries) toward IF/ID. A redirect kills in-flight and
// buffered fetches (epoch tag), pulses Flush and restarts fetch at the target.
// Ports:
//   clk, reset          : clock, async active-low reset
//   PcSel, BrPC         : redirect request and target from branch resolution
//   imem_req, imem_addr : fetch request/address (combinational, credit-limited)
//   imem_rdata          : fetch data, valid the cycle after imem_req
//   if_valid, if_ready  : IF/ID handshake for the queue head
//   if_pc, if_instr     : head entry (zero while empty)
//   Flush               : kill IF/ID and ID/EX this cycle (combinational from PcSel)
module fetch_redirect_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     PC_W     = FETCH_PC_W,
  parameter int unsigned     INS_W    = FETCH_INS_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PcSel,
  input  logic [31:0]      BrPC,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [INS_W-1:0] imem_rdata,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [PC_W-1:0]  if_pc,
  output logic [INS_W-1:0] if_instr,
  output logic             Flush
);

  localparam int unsigned OCC_W = FETCH_CNT_W + 1;

  logic [PC_W-1:0]        pc_q, pc_d;
  logic                   epoch_q, epoch_d;
  logic                   inflight_q, inflight_d;
  logic                   inflight_epoch_q, inflight_epoch_d;
  logic [PC_W-1:0]        inflight_pc_q, inflight_pc_d;

  logic                   fifo_push, fifo_pop;
  fetch_entry_t           fifo_wdata, fifo_rdata;
  logic [FETCH_CNT_W-1:0] fifo_count;
  logic [OCC_W-1:0]       occupancy;
  logic                   unused_brpc_bits;

  assign unused_brpc_bits = ^{BrPC[31:PC_W], BrPC[1:0]};

  fetch_fifo u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (PcSel),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

  // Credit, response acceptance and PC/epoch next-state.
  always_comb begin
    pc_d             = pc_q;
    epoch_d          = epoch_q;
    inflight_d       = 1'b0;
    inflight_epoch_d = inflight_epoch_q;
    inflight_pc_d    = inflight_pc_q;

    if_valid = (fifo_count != '0);
    fifo_pop = if_valid && if_ready;

    // Slots already committed: buffered + returning next cycle - leaving now.
    occupancy = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(fifo_pop);
    // reset gating keeps the request low while reset is held, independent of clk.
    imem_req  = reset && !PcSel && (occupancy < OCC_W'(FETCH_DEPTH));
    imem_addr = pc_q;
    Flush     = reset && PcSel;

    // A stale-epoch or same-cycle-redirect response is dropped.
    fifo_push        = inflight_q && (inflight_epoch_q == epoch_q) && !PcSel;
    fifo_wdata.pc    = FETCH_PC_W'(inflight_pc_q);
    fifo_wdata.instr = FETCH_INS_W'(imem_rdata);

    if (PcSel) begin
      pc_d    = {BrPC[PC_W-1:2], 2'b00};
      epoch_d = ~epoch_q;
    end else if (imem_req) begin
      pc_d             = pc_q + PC_W'(4);
      inflight_d       = 1'b1;
      inflight_epoch_d = epoch_q;
      inflight_pc_d    = pc_q;
    end

    if_pc    = if_valid ? PC_W'(fifo_rdata.pc) : '0;
    if_instr = if_valid ? INS_W'(fifo_rdata.instr) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q             <= RESET_PC;
      epoch_q          <= 1'b0;
      inflight_q       <= 1'b0;
      inflight_epoch_q <= 1'b0;
      inflight_pc_q    <= '0;
    end else begin
      pc_q             <= pc_d;
      epoch_q          <= epoch_d;
      inflight_q       <= inflight_d;
      inflight_epoch_q <= inflight_epoch_d;
      inflight_pc_q    <= inflight_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: directed scenarios plus randomized redirect/backpressure,
// checked against a transaction-level model (queue of PCs, one pending fetch slot).
module tb_fetch_redirect_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PcSel = 1'b0;
  logic [31:0] BrPC = '0;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [8:0]  if_pc;
  logic [31:0] if_instr;
  logic        Flush;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int mq[$];
  int mpc;
  bit mpend;
  int mpend_pc;
  int snext;

  always #5 clk = ~clk;

  fetch_redirect_unit dut (
    .clk        (clk),
    .reset      (reset),
    .PcSel      (PcSel),
    .BrPC       (BrPC),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_pc      (if_pc),
    .if_instr   (if_instr),
    .Flush      (Flush)
  );

  // Memory image: distinct word per address.
  function automatic logic [31:0] img(input logic [8:0] a);
    logic [31:0] x;
    x = 32'(a);
    return (x * 32'h9E37_79B1) ^ {a, 23'h0} ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check at negedge, advance model, answer imem.
  task automatic cycle(input bit sel, input logic [31:0] br, input bit rdy);
    bit         hs;
    bit         ereq;
    logic       req_s;
    logic [8:0] addr_s;
    PcSel    = sel;
    BrPC     = br;
    if_ready = rdy;
    @(negedge clk);
    hs   = (mq.size() > 0) && rdy;
    ereq = !sel && ((mq.size() + int'(mpend) - int'(hs)) < 2);
    chk("imem_req", 32'(imem_req), 32'(ereq));
    if (ereq) chk("imem_addr", 32'(imem_addr), 32'(mpc));
    chk("flush", 32'(Flush), 32'(sel));
    chk("if_valid", 32'(if_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("if_pc", 32'(if_pc), 32'(mq[0]));
      chk("if_instr", if_instr, img(9'(mq[0])));
    end
    chk("no_full_push", 32'(dut.u_fifo.push && (dut.u_fifo.count == 2'd2) && !dut.u_fifo.pop), 32'd0);
    if (hs && !sel) begin
      chk("order", 32'(if_pc), 32'(snext));
      snext = (32'(if_pc) + 4) & 32'h1FF;
    end
    req_s  = imem_req;
    addr_s = imem_addr;
    if (hs) void'(mq.pop_front());
    if (sel) begin
      mq.delete();
      mpend = 1'b0;
      mpc   = int'(br & 32'h1FC);
      snext = mpc;
    end else begin
      if (mpend) mq.push_back(mpend_pc);
      if (ereq) begin
        mpend    = 1'b1;
        mpend_pc = mpc;
        mpc      = (mpc + 4) & 32'h1FF;
      end else begin
        mpend = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    imem_rdata = req_s ? img(addr_s) : $urandom();
  endtask

  // Asserts reset with PcSel high (reset must win), checks immediate outputs, releases.
  task automatic apply_reset();
    PcSel    = 1'b1;
    BrPC     = 32'h80;
    if_ready = 1'b1;
    reset    = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_flush", 32'(Flush), 32'd0);
    chk("rst_pc", 32'(if_pc), 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    PcSel = 1'b0;
    mq.delete();
    mpc   = 0;
    mpend = 1'b0;
    snext = 0;
    imem_rdata = $urandom();
  endtask

  initial begin
    #2;
    apply_reset();
    repeat (20) cycle(($urandom_range(0, 7) == 0), $urandom(), ($urandom_range(0, 3) != 0));

    // Mid-stream reset, then sequential fetch and redirect with 0x10 in flight.
    apply_reset();
    chk("t1_addr0", 32'(imem_addr), 32'h0);
    cycle(1'b0, '0, 1'b1);
    chk("t1_addr1", 32'(imem_addr), 32'h4);
    chk("t1_valid_lo", 32'(if_valid), 32'd0);
    cycle(1'b0, '0, 1'b1);
    chk("t1_addr2", 32'(imem_addr), 32'h8);
    chk("t1_valid_hi", 32'(if_valid), 32'd1);
    chk("t2_pc0", 32'(if_pc), 32'h0);
    chk("t2_instr0", if_instr, img(9'h0));
    cycle(1'b0, '0, 1'b1);
    chk("t2_pc4", 32'(if_pc), 32'h4);
    cycle(1'b0, '0, 1'b1);
    chk("t2_pc8", 32'(if_pc), 32'h8);
    cycle(1'b0, '0, 1'b1);
    chk("t2_pcC", 32'(if_pc), 32'hC);
    cycle(1'b1, 32'h40, 1'b1);
    chk("t4_killed", 32'(if_valid), 32'd0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    chk("t4_tgt_valid", 32'(if_valid), 32'd1);
    chk("t4_tgt_pc", 32'(if_pc), 32'h40);
    cycle(1'b0, '0, 1'b1);
    chk("t4_next_pc", 32'(if_pc), 32'h44);

    // Backpressure from start: queue fills with 0,4 and fetch stalls.
    apply_reset();
    repeat (5) cycle(1'b0, '0, 1'b0);
    chk("t3_valid", 32'(if_valid), 32'd1);
    chk("t3_head", 32'(if_pc), 32'h0);
    chk("t3_pc_hold", 32'(imem_addr), 32'h8);
    cycle(1'b0, '0, 1'b1);
    chk("t3_pc4", 32'(if_pc), 32'h4);
    cycle(1'b0, '0, 1'b1);
    chk("t3_pc8", 32'(if_pc), 32'h8);

    // PC wrap at the top of the 9-bit space.
    cycle(1'b1, 32'h1F8, 1'b1);
    chk("t5_addr_1f8", 32'(imem_addr), 32'h1F8);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    chk("t5_wrap_addr", 32'(imem_addr), 32'h000);
    chk("t5_pc_1f8", 32'(if_pc), 32'h1F8);
    cycle(1'b0, '0, 1'b1);
    chk("t5_pc_1fc", 32'(if_pc), 32'h1FC);
    cycle(1'b0, '0, 1'b1);
    chk("t5_pc_000", 32'(if_pc), 32'h000);

    // Unaligned target with a handshake in the same cycle.
    chk("t6_pre_valid", 32'(if_valid), 32'd1);
    cycle(1'b1, 32'h42, 1'b1);
    chk("t6_empty", 32'(if_valid), 32'd0);
    chk("t6_addr", 32'(imem_addr), 32'h40);

    // Randomized redirects and backpressure.
    repeat (400) cycle(($urandom_range(0, 9) == 0), $urandom(), ($urandom_range(0, 9) < 7));
    apply_reset();
    repeat (200) cycle(($urandom_range(0, 15) == 0), $urandom(), ($urandom_range(0, 9) < 5));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
